// File: rtl/sudoku_pkg.sv
// Shared types for the sudoku grid blocks: grid length, one-hot type, row_bias states.
// GRID_LEN defaults to 9 when the build does not supply it.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

package sudoku_pkg;

    localparam int LEN  = `GRID_LEN;
    localparam int IDXW = $clog2(LEN);

    typedef logic [LEN-1:0] onehot_t;

    typedef enum logic {
        SHUFFLE,
        READY
    } row_bias_state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400) with seed parameter and advance enable.
// Shared by row_bias and the grid-level seed generator.
module lfsr16
    import sudoku_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] state
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SEED;
        end else if (enable) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/row_bias.sv
// Per-row bias responder: shuffled one-hot permutation served with one-cycle latency.
// Optional one-hot request checker enabled by ROW_BIAS_ONEHOT_CHECK_EN (adds err).
module row_bias
    import sudoku_pkg::*;
#(
    parameter int          LEN  = sudoku_pkg::LEN,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [LEN-1:0] biasidx,
    output logic [LEN-1:0] valtotry,
    input  logic           reshuffle,
    output logic           ready
`ifdef ROW_BIAS_ONEHOT_CHECK_EN
    ,
    output logic           err
`endif
);

    localparam int KW = $clog2(LEN);

    row_bias_state_e state;
    row_bias_state_e state_nx;

    logic [LEN-1:0] perm [LEN];
    logic [LEN-1:0] sel;
    logic [KW-1:0]  k;
    logic [KW-1:0]  j;
    logic [KW:0]    k_p1;
    logic [KW:0]    j_w;
    logic [15:0]    lfsr;
    logic           shuf;
    logic           unused_bits;

    assign shuf  = (state == SHUFFLE);
    assign ready = (state == READY);

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .enable(shuf),
        .state (lfsr)
    );

    // Fisher-Yates index: j drawn from 0..k
    assign k_p1 = {1'b0, k} + 1'b1;
    assign j_w  = {1'b0, lfsr[KW-1:0]} % k_p1;
    assign j    = j_w[KW-1:0];

    assign unused_bits = ^{lfsr[15:KW], j_w[KW]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SHUFFLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            SHUFFLE: begin
                if (k == KW'(1)) begin
                    state_nx = READY;
                end
            end
            READY: begin
                if (reshuffle) begin
                    state_nx = SHUFFLE;
                end
            end
            default: state_nx = SHUFFLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LEN; i++) begin
                perm[i] <= {{(LEN-1){1'b0}}, 1'b1} << i;
            end
            k <= KW'(LEN - 1);
        end else if (shuf) begin
            perm[k] <= perm[j];
            perm[j] <= perm[k];
            k       <= k - 1'b1;
        end else if (reshuffle) begin
            k <= KW'(LEN - 1);
        end
    end

    // Multi-hot requests simply OR the selected entries
    always_comb begin
        sel = '0;
        for (int i = 0; i < LEN; i++) begin
            if (biasidx[i]) begin
                sel = sel | perm[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valtotry <= '0;
        end else if (ready) begin
            valtotry <= sel;
        end else begin
            valtotry <= '0;
        end
    end

`ifdef ROW_BIAS_ONEHOT_CHECK_EN
    logic multi;

    assign multi = |(biasidx & (biasidx - 1'b1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (ready && multi) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_row_bias.sv
// Randomized and directed bench for row_bias against a whole-shuffle reference model.
// Builds with or without ROW_BIAS_ONEHOT_CHECK_EN.
module tb_row_bias;
    import sudoku_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [LEN-1:0] ALL = {LEN{1'b1}};

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           reshuffle = 1'b0;
    logic [LEN-1:0] biasidx = '0;
    logic [LEN-1:0] valtotry;
    logic           ready;
`ifdef ROW_BIAS_ONEHOT_CHECK_EN
    logic           err;
`endif

    int total = 0;
    int bad   = 0;

    logic [LEN-1:0] m_perm [LEN];
    logic [LEN-1:0] p1 [LEN];
    logic [15:0]    m_lfsr;
    int             m_busy;
    logic [LEN-1:0] m_val;
    logic           m_err;
    logic [LEN-1:0] or_all;

    row_bias #(
        .LEN (LEN),
        .SEED(SEED)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .biasidx  (biasidx),
        .valtotry (valtotry),
        .reshuffle(reshuffle),
        .ready    (ready)
`ifdef ROW_BIAS_ONEHOT_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] adv(input logic [15:0] s);
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    // Computes the full post-shuffle permutation at once
    task automatic plan_shuffle();
        logic [LEN-1:0] t;
        int j;
        for (int k = LEN - 1; k >= 1; k--) begin
            j = (int'(m_lfsr) % (1 << IDXW)) % (k + 1);
            t = m_perm[k];
            m_perm[k] = m_perm[j];
            m_perm[j] = t;
            m_lfsr = adv(m_lfsr);
        end
        m_busy = LEN - 1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LEN; i++) m_perm[i] = ALL & (1 << i);
        m_lfsr = SEED;
        m_val = '0;
        m_err = 1'b0;
        plan_shuffle();
    endtask

    task automatic model_edge(input logic [LEN-1:0] b, input logic rs);
        m_val = '0;
        if (m_busy > 0) begin
            m_busy--;
        end else begin
            for (int i = 0; i < LEN; i++)
                if (b[i]) m_val = m_val | m_perm[i];
            if ($countones(b) > 1) m_err = 1'b1;
            if (rs) plan_shuffle();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_val"}, 32'(valtotry), 32'(m_val));
        check({tag, "_rdy"}, 32'(ready), 32'(m_busy == 0));
`ifdef ROW_BIAS_ONEHOT_CHECK_EN
        check({tag, "_err"}, 32'(err), 32'(m_err));
`endif
    endtask

    task automatic step(input logic [LEN-1:0] b, input logic rs,
                        input string tag);
        biasidx = b;
        reshuffle = rs;
        @(posedge clock);
        #1;
        model_edge(b, rs);
        check_outs(tag);
    endtask

    task automatic sweep(input string tag);
        or_all = '0;
        for (int i = 0; i < LEN; i++) begin
            step(ALL & (1 << i), 1'b0, tag);
            check({tag, "_1hot"}, 32'($countones(valtotry)), 32'd1);
            or_all = or_all | valtotry;
        end
        step('0, 1'b0, tag);
        check({tag, "_or"}, 32'(or_all), 32'(ALL));
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check({tag, "_val"}, 32'(valtotry), 32'd0);
        check({tag, "_rdy"}, 32'(ready), 32'd0);
`ifdef ROW_BIAS_ONEHOT_CHECK_EN
        check({tag, "_err"}, 32'(err), 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_outs("rst");
        #12;
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < LEN - 1; i++) step('0, 1'b0, "boot");
        for (int i = 0; i < LEN; i++) p1[i] = m_perm[i];
        sweep("sweep1");

        repeat (3) step('0, 1'b0, "idle");

        step(ALL & 4, 1'b1, "resh");
        for (int i = 0; i < LEN - 1; i++) step(ALL & 4, 1'b0, "busy");
        sweep("sweep2");

        step(ALL & 3, 1'b0, "multi");
        step(ALL & 1, 1'b0, "after1");
        step(ALL & 2, 1'b0, "after2");

        for (int n = 0; n < 400; n++) begin
            logic [LEN-1:0] b;
            int mode;
            mode = $urandom_range(2);
            if (mode == 0) b = '0;
            else if (mode == 1) b = ALL & (1 << $urandom_range(LEN - 1));
            else b = ALL & LEN'($urandom());
            step(b, ($urandom_range(19) == 0), "rand");
        end

        for (int i = 0; i < LEN && m_busy > 0; i++) step('0, 1'b0, "drain");
        step(ALL & 1, 1'b0, "pre_rst");
        async_reset("arst_ready");

        repeat (3) step('0, 1'b0, "k5");
        async_reset("arst_k5");

        for (int i = 0; i < LEN - 1; i++) step('0, 1'b0, "reboot");
        for (int i = 0; i < LEN; i++) begin
            step(ALL & (1 << i), 1'b0, "repro");
            check("repro_p1", 32'(valtotry), 32'(p1[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
